store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  In-order store buffer between the EX/MEM pipeline register and the 256x64 data memory.
//  Accepts stores from the MEM stage and retires one per cycle to the memory's synchronous write port.
//  Serves MEM-stage loads by forwarding the youngest matching buffered store.
//  Otherwise it passes through the memory's asynchronous read data.
// PARAMETERS
//  DEPTH  4   buffer entries, power of two, >=2
//  AW     8   data-memory address width (word address)
//  DW     64  data width
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  st_valid   in   1       store request from MEM stage
//  st_addr    in   AW      store word address
//  st_data    in   DW      store data
//  st_ready   out  1       buffer can accept store (= !full)
//  ld_addr    in   AW      MEM-stage load word address (read every cycle)
//  ld_data    out  DW      load result: forwarded or memory data
//  ld_fwd     out  1       ld_data came from buffer
//  drain_hold in   1       suppress retirement this cycle
//  mem_raddr  out  AW      to datamem raddr (= ld_addr)
//  mem_dout   in   DW      from datamem dout (async)
//  mem_waddr  out  AW      to datamem waddr
//  mem_wdata  out  DW      to datamem wdata
//  mem_wea    out  1       to datamem wea
//  count      out  log2(DEPTH)+1  valid entries
// BEHAVIOUR
//  - Circular FIFO: head/tail pointers of log2(DEPTH) bits, wrap modulo DEPTH, plus count.
//  - Push at the edge when st_valid && st_ready; the entry is written at tail, tail++.
//  - Retire: mem_wea = (count!=0) && !drain_hold && !rst.
//    mem_waddr/mem_wdata = head entry, combinational; head++ at the same edge.
//  - Latency: a store accepted at edge N drives mem_wea in the cycle after N.
//    It is in memory after edge N+1 at the earliest.
//  - Simultaneous push+retire: count unchanged; allowed when not full.
//  - Full: st_ready=0; st_valid ignored (no write-through, no overwrite), even if retiring that cycle.
//  - Empty: mem_wea=0; mem_waddr/mem_wdata are don't-care but must not be X (drive head entry).
//  - Forwarding is combinational: compare ld_addr against all valid entries.
//    - On any match, ld_fwd=1 and ld_data = data of the youngest match (nearest tail).
//    - With no match, ld_fwd=0 and ld_data=mem_dout.
//    - The entry retiring this cycle still matches, because memory updates only at the edge.
//    - A store being pushed in the same cycle is NOT visible to the load.
//  - Duplicate addresses may coexist; retirement order = acceptance order, so the last store wins in memory.
//  - Reset: head=tail=count=0, all entries invalid, mem_wea=0, st_ready=1 in the cycle after rst.
//    Reset mid-operation discards pending stores; no partial retirement in the rst cycle.
//  - ld_data/ld_fwd have no reset value (combinational). With buffer empty, ld_data=mem_dout.
// STRUCTURE
//  - Shared package pipeline_pkg: DMEM_AW=8, DMEM_DW=64, SB_DEPTH default.
//    Also holds the sb_entry_t {valid, addr, data} typedef.
//  - Sub-module sb_fwd_match: per-entry address compare plus youngest-first priority select.
//    Inputs are entries, head, count and ld_addr; outputs are hit and the selected data.
//  - Top holds pointers, count, entry array, retire logic.
// TESTING
//  1. rst then idle -> count=0, st_ready=1, mem_wea=0 every cycle; ld_addr=8'h10 gives ld_data=mem_dout, ld_fwd=0.
//  2. Store (0x20,0xAAAA) at edge N -> mem_wea=1, mem_waddr=0x20, mem_wdata=0xAAAA in the cycle after N.
//     count back to 0 after edge N+1.
//  3. drain_hold=1; push 4 stores -> st_ready=0, count=4; 5th st_valid dropped.
//     Release hold -> 4 writes on 4 consecutive cycles in push order.
//  4. Hold; push (0x30,1) then (0x30,2); ld_addr=0x30 -> ld_fwd=1, ld_data=2.
//     After drain, ld_fwd=0 and mem[0x30]=2.
//  5. Push+retire each cycle for 20 cycles with pointer wrap -> count stays 1, no drop, memory matches a reference model.
//  6. 3 entries pending, rst for 1 cycle -> no mem_wea during or after; count=0; memory unchanged.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Shared data-memory widths, store-buffer depth and entry type.
//  Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    localparam int DMEM_AW  = 8;
    localparam int DMEM_DW  = 64;
    localparam int SB_DEPTH = 4;

    // One buffered store: occupancy flag, word address and write data.
    typedef struct packed {
        logic               valid;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] data;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module   : sb_fwd_match
//  Purpose  : Compares a load address against every occupied buffer entry and
//             returns the data of the youngest (closest to tail) match.
//  Revision : 1.0  initial release
// ============================================================================
module sb_fwd_match
    import pipeline_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  sb_entry_t                  entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [$clog2(DEPTH):0]     count_i,
    input  logic [DMEM_AW-1:0]         ld_addr_i,
    output logic                       hit_o,
    output logic [DMEM_DW-1:0]         data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Walk from oldest to youngest; a later match overrides, so the youngest wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PW-1:0] idx;
            idx = head_i + PW'(k);
            if ((CW'(k) < count_i) && entries_i[idx].valid &&
                (entries_i[idx].addr == ld_addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : In-order store FIFO between MEM stage and the data memory.
//             Retires one store per cycle to the synchronous write port and
//             forwards the youngest matching store to MEM-stage loads.
//  Revision : 1.0  initial release
// ============================================================================
module store_buffer
    import pipeline_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = DMEM_AW,   // must equal DMEM_AW (entry type width)
    parameter int DW    = DMEM_DW    // must equal DMEM_DW (entry type width)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    input  logic [AW-1:0]            ld_addr,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_fwd,
    input  logic                     drain_hold,
    output logic [AW-1:0]            mem_raddr,
    input  logic [DW-1:0]            mem_dout,
    output logic [AW-1:0]            mem_waddr,
    output logic [DW-1:0]            mem_wdata,
    output logic                     mem_wea,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    sb_entry_t     entries_q [DEPTH];

    logic          w_full;
    logic          w_push;
    logic          w_retire;
    logic          w_hit;
    logic [DW-1:0] w_fwd_data;

    // A full buffer refuses stores even when it is retiring this cycle.
    assign w_full   = (count_q == CW'(DEPTH));
    assign w_push   = st_valid && !w_full;
    assign w_retire = (count_q != '0) && !drain_hold && !rst;

    // Pointer and occupancy next-state; power-of-two depth gives free wrap.
    always_comb begin
        head_d  = w_retire ? head_q + PW'(1) : head_q;
        tail_d  = w_push   ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(w_push) - CW'(w_retire);
    end

    // Entry storage and pointer state; reset clears every entry so outputs never go X.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Push and retire never target the same slot: that needs count 0 or full.
            if (w_push) begin
                entries_q[tail_q] <= '{valid: 1'b1, addr: st_addr, data: st_data};
            end
            if (w_retire) begin
                entries_q[head_q].valid <= 1'b0;
            end
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries_i (entries_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .ld_addr_i (ld_addr),
        .hit_o     (w_hit),
        .data_o    (w_fwd_data)
    );

    assign st_ready  = !w_full;
    assign mem_wea   = w_retire;
    assign mem_waddr = entries_q[head_q].addr;
    assign mem_wdata = entries_q[head_q].data;
    assign mem_raddr = ld_addr;
    assign ld_fwd    = w_hit;
    assign ld_data   = w_hit ? w_fwd_data : mem_dout;
    assign count     = count_q;

endmodule
`default_nettype wire
